// File: rtl/alu_arbiter.sv
// Purpose: shares one combinational ALU between requester 0 (CPU) and requester 1 (aux/DMA).
// Latency: accept at edge N, operands on alu_* after N, result/flags captured at N+1, response pulse N+1..N+2.
// Backpressure: reqN_ready is high only for the granted requester in IDLE or RESP, never in EXEC.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b     requester N handshake and operation (N = 0, 1)
//   resp0_valid, resp1_valid    one-cycle response pulse for the owning requester
//   resp_result, resp_c/z/s     captured result and owner's flag register (held between pulses)
//   busy                        high while an op is in EXEC or RESP
//   alu_op/a/b                  registered operation driven to the ALU
//   alu_result, alu_c/z/s       ALU outputs
// Build option: define ALU_ARB_ROUND_ROBIN_EN for alternating tie-break; default is fixed
// priority with requester 0 winning every tie.
module alu_arbiter #(
   parameter int OP_W   = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              resp0_valid,
   output logic              resp1_valid,
   output logic [DATA_W-1:0] resp_result,
   output logic              resp_c,
   output logic              resp_z,
   output logic              resp_s,
   output logic              busy,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_c,
   input  logic              alu_z,
   input  logic              alu_s
);

   localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

   state_t            state_q, state_d;
   logic [OP_W-1:0]   alu_op_q, alu_op_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic [2:0]        flags0_q, flags0_d;        // {c, z, s}
   logic [2:0]        flags1_q, flags1_d;
   logic              resp0_valid_q, resp0_valid_d;
   logic              resp1_valid_q, resp1_valid_d;
   logic [DATA_W-1:0] resp_result_q, resp_result_d;
   logic [2:0]        resp_czs_q, resp_czs_d;

   logic              can_accept;
   logic              accept;
   logic              grant;                     // 0 = requester 0, 1 = requester 1
   logic              tie_grant;
   logic [2:0]        owner_flags;

   // Grant selection; reset masks ready so no handshake is lost across a reset edge.
   always_comb begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      tie_grant = ~last_grant_q;
`else
      // last_grant is still tracked so the policy can be switched without retiming.
      tie_grant = last_grant_q & 1'b0;
`endif
      can_accept = !reset && ((state_q == ST_IDLE) || (state_q == ST_RESP));
      if (req0_valid && req1_valid) begin
         grant = tie_grant;
      end else begin
         grant = req1_valid;
      end
      accept = can_accept && (req0_valid || req1_valid);
   end

   always_comb begin
      state_d       = state_q;
      alu_op_d      = alu_op_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      owner_d       = owner_q;
      last_grant_d  = last_grant_q;
      flags0_d      = flags0_q;
      flags1_d      = flags1_q;
      resp0_valid_d = 1'b0;
      resp1_valid_d = 1'b0;
      resp_result_d = resp_result_q;
      resp_czs_d    = resp_czs_q;
      owner_flags   = owner_q ? flags1_q : flags0_q;

      case (state_q)
         ST_IDLE, ST_RESP: begin
            if (accept) begin
               state_d      = ST_EXEC;
               alu_op_d     = grant ? req1_op : req0_op;
               alu_a_d      = grant ? req1_a  : req0_a;
               alu_b_d      = grant ? req1_b  : req0_b;
               owner_d      = grant;
               last_grant_d = grant;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            // Only arithmetic ops update flags; everything else leaves the owner's flags alone.
            if ((alu_op_q == OP_ADD) || (alu_op_q == OP_SUB)) begin
               owner_flags = {alu_c, alu_z, alu_s};
            end
            if (owner_q) begin
               flags1_d = owner_flags;
            end else begin
               flags0_d = owner_flags;
            end
            state_d       = ST_RESP;
            resp_result_d = alu_result;
            resp_czs_d    = owner_flags;
            resp0_valid_d = !owner_q;
            resp1_valid_d = owner_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         alu_op_q      <= '0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         owner_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         flags0_q      <= 3'b000;
         flags1_q      <= 3'b000;
         resp0_valid_q <= 1'b0;
         resp1_valid_q <= 1'b0;
         resp_result_q <= '0;
         resp_czs_q    <= 3'b000;
      end else begin
         state_q       <= state_d;
         alu_op_q      <= alu_op_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         owner_q       <= owner_d;
         last_grant_q  <= last_grant_d;
         flags0_q      <= flags0_d;
         flags1_q      <= flags1_d;
         resp0_valid_q <= resp0_valid_d;
         resp1_valid_q <= resp1_valid_d;
         resp_result_q <= resp_result_d;
         resp_czs_q    <= resp_czs_d;
      end
   end

   assign req0_ready  = accept && !grant;
   assign req1_ready  = accept && grant;
   assign resp0_valid = resp0_valid_q;
   assign resp1_valid = resp1_valid_q;
   assign resp_result = resp_result_q;
   assign resp_c      = resp_czs_q[2];
   assign resp_z      = resp_czs_q[1];
   assign resp_s      = resp_czs_q[0];
   assign busy        = (state_q != ST_IDLE);
   assign alu_op      = alu_op_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by randomized traffic, all checked
// against a transaction-level reference model (response due two cycles after acceptance).
module tb_alu_arbiter;

   logic       clk;
   logic       reset;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0] req0_op, req1_op;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic       resp0_valid, resp1_valid;
   logic [7:0] resp_result;
   logic       resp_c, resp_z, resp_s, busy;
   logic [3:0] alu_op;
   logic [7:0] alu_a, alu_b, alu_result;
   logic       alu_c, alu_z, alu_s;

   alu_arbiter #(.OP_W(4), .DATA_W(8)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_result(resp_result),
      .resp_c(resp_c), .resp_z(resp_z), .resp_s(resp_s), .busy(busy),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z), .alu_s(alu_s)
   );

   // Behavioural ALU: returns {c, z, s, result}.
   function automatic logic [10:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] t;
      logic [7:0] r;
      logic       c;
      c = 1'b0;
      case (op)
         4'h0: begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8]; end
         4'h1: begin r = a - b; c = (a < b); end
         4'h6: r = ~a;
         4'h8: begin t = {1'b0, a} + 9'd1; r = t[7:0]; c = t[8]; end
         4'h9: begin r = a - 8'd1; c = (a == 8'd0); end
         4'he: r = 8'h00;
         4'hf: r = 8'hff;
         default: r = a ^ b;
      endcase
      return {c, (r == 8'h00), r[7], r};
   endfunction

   always_comb {alu_c, alu_z, alu_s, alu_result} = alu_ref(alu_op, alu_a, alu_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct { int due; int owner; logic [7:0] res; logic [2:0] czs; } exp_t;
   typedef struct { int owner; logic [7:0] res; logic [2:0] czs; int cyc; } obs_t;

   logic [19:0] q0[$];
   logic [19:0] q1[$];
   exp_t        rq[$];
   obs_t        obs[$];
   logic [2:0]  m_flags[2];
   int          m_last_grant, last_acc, cyc;
   logic [3:0]  m_alu_op;
   logic [7:0]  m_alu_a, m_alu_b, m_res;
   logic [2:0]  m_czs;
   logic        acc_evt;
   int          n_cmp = 0;
   int          n_mis = 0;
   int          exp_own[8];

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic model_reset();
      rq.delete();
      m_flags[0] = 3'b000;
      m_flags[1] = 3'b000;
      m_last_grant = 1;
      last_acc = -10;
      m_alu_op = 4'h0; m_alu_a = 8'h00; m_alu_b = 8'h00;
      m_res = 8'h00; m_czs = 3'b000;
   endtask

   task automatic drive();
      req0_valid = (q0.size() > 0);
      if (q0.size() > 0) {req0_op, req0_a, req0_b} = q0[0];
      req1_valid = (q1.size() > 0);
      if (q1.size() > 0) {req1_op, req1_a, req1_b} = q1[0];
   endtask

   // One clock cycle: drive, sample at negedge, compare, advance the model.
   task automatic tick();
      exp_t        e;
      obs_t        ob;
      logic [10:0] f;
      logic [3:0]  op;
      logic [7:0]  a, b;
      int          g;
      logic        can, e_r0, e_r1, e_v0, e_v1, e_busy;
      drive();
      @(negedge clk);
      acc_evt = 1'b0;
      can = !reset && (cyc != last_acc + 1);
      g = -1;
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
         g = (m_last_grant == 1) ? 0 : 1;
`else
         g = 0;
`endif
      end else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;
      e_r0 = can && (g == 0);
      e_r1 = can && (g == 1);
      e_v0 = 1'b0;
      e_v1 = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         e = rq.pop_front();
         e_v0 = (e.owner == 0);
         e_v1 = (e.owner == 1);
         m_res = e.res;
         m_czs = e.czs;
      end
      e_busy = (cyc == last_acc + 1) || (cyc == last_acc + 2);
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("resp0_valid", resp0_valid, e_v0);
      chk("resp1_valid", resp1_valid, e_v1);
      chk("resp_result", resp_result, m_res);
      chk("resp_czs", {resp_c, resp_z, resp_s}, m_czs);
      chk("busy", busy, e_busy);
      chk("alu_op", alu_op, m_alu_op);
      chk("alu_a", alu_a, m_alu_a);
      chk("alu_b", alu_b, m_alu_b);
      if (resp0_valid || resp1_valid) begin
         ob.owner = resp1_valid ? 1 : 0;
         ob.res = resp_result;
         ob.czs = {resp_c, resp_z, resp_s};
         ob.cyc = cyc;
         obs.push_back(ob);
      end
      if (reset) begin
         model_reset();
      end else if (can && g >= 0) begin
         {op, a, b} = (g == 1) ? q1[0] : q0[0];
         f = alu_ref(op, a, b);
         if (op == 4'h0 || op == 4'h1) m_flags[g] = f[10:8];
         e.due = cyc + 2; e.owner = g; e.res = f[7:0]; e.czs = m_flags[g];
         rq.push_back(e);
         m_last_grant = g;
         last_acc = cyc;
         m_alu_op = op; m_alu_a = a; m_alu_b = b;
         if (g == 1) void'(q1.pop_front());
         else void'(q0.pop_front());
         acc_evt = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int maxc);
      int n;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || rq.size() > 0) && n < maxc) begin
         tick();
         n++;
      end
      chk("drain", (q0.size() == 0 && q1.size() == 0 && rq.size() == 0), 1'b1);
   endtask

   task automatic wait_acc();
      logic got;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         got = acc_evt;
      end
      chk("wait_accept", got, 1'b1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      obs.delete();
   endtask

   task automatic chk_resp(input string tag, input int idx, input int owner, input logic [7:0] res, input logic [2:0] czs);
      chk({tag, "_count"}, (obs.size() > idx), 1'b1);
      if (obs.size() > idx) begin
         chk({tag, "_owner"}, obs[idx].owner, owner);
         chk({tag, "_result"}, obs[idx].res, res);
         chk({tag, "_czs"}, obs[idx].czs, czs);
      end
   endtask

   initial begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_own = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
      exp_own = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
      reset = 1'b1;
      req0_valid = 1'b0; req0_op = 4'h0; req0_a = 8'h00; req0_b = 8'h00;
      req1_valid = 1'b0; req1_op = 4'h0; req1_a = 8'h00; req1_b = 8'h00;
      cyc = 0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      reset = 1'b0;
      acc_evt = 1'b0;

      // Reset state is checked by the first ticks; then ADD 0x7F + 0x01.
      tick();
      q0.push_back({4'h0, 8'h7f, 8'h01});
      run(20);
      chk_resp("t1", 0, 0, 8'h80, 3'b001);

      // SUB on requester 1, then a NOT on requester 0 shows its untouched flags.
      q1.push_back({4'h1, 8'h00, 8'h01});
      run(20);
      q0.push_back({4'h6, 8'h3c, 8'h00});
      run(20);
      chk_resp("t2_sub", 1, 1, 8'hff, 3'b101);
      chk_resp("t2_not", 2, 0, 8'hc3, 3'b001);

      // Both requesters continuously valid, four ops each.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         q0.push_back({4'h0, 8'(i), 8'h10});
         q1.push_back({4'h1, 8'(i), 8'h20});
      end
      run(60);
      chk("t3_count", obs.size(), 8);
      for (int i = 0; i < 8 && i < obs.size(); i++) begin
         chk("t3_grant_order", obs[i].owner, exp_own[i]);
         if (i > 0) chk("t3_spacing", obs[i].cyc - obs[i-1].cyc, 2);
      end

      // ADD 0xFF + 0x01 sets C and Z; INC keeps them.
      do_reset();
      q0.push_back({4'h0, 8'hff, 8'h01});
      q0.push_back({4'h8, 8'h05, 8'h05});
      run(20);
      chk_resp("t4_add", 0, 0, 8'h00, 3'b110);
      chk_resp("t4_inc", 1, 0, 8'h06, 3'b110);

      // Reset during EXEC of a SET: no response, flags cleared, next tie goes to requester 0.
      do_reset();
      q0.push_back({4'h0, 8'hff, 8'h01});
      run(20);
      obs.delete();
      q0.push_back({4'hf, 8'h00, 8'h00});
      wait_acc();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk("t5_no_resp", obs.size(), 0);
      q0.push_back({4'h6, 8'h0f, 8'h00});
      q1.push_back({4'h6, 8'hf0, 8'h00});
      run(20);
      chk("t5_count", obs.size(), 2);
      chk_resp("t5_tie", 0, 0, 8'hf0, 3'b000);

      // Requester 0 raises valid during EXEC and drops it before being accepted.
      do_reset();
      q1.push_back({4'h0, 8'h11, 8'h22});
      wait_acc();
      q0.push_back({4'h1, 8'h33, 8'h44});
      tick();
      q0.delete();
      run(20);
      chk("t6_count", obs.size(), 1);
      chk_resp("t6", 0, 1, 8'h33, 3'b000);
      chk("t6_alu_op", alu_op, 4'h0);
      chk("t6_alu_a", alu_a, 8'h11);

      // Randomized traffic with occasional resets.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0 && q0.size() < 3) q0.push_back(20'($urandom));
         if ($urandom_range(0, 2) == 0 && q1.size() < 3) q1.push_back(20'($urandom));
         reset = ($urandom_range(0, 99) == 0);
         tick();
      end
      reset = 1'b0;
      run(200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
